// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder split into STAGES equal chunks,
// one chunk per clock, carry registered between stages, valid/ready on both sides.
// Optional feature macro: PIPE_ADDER_OVF_EN (adds the signed-overflow output ovf).
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = (STAGES == 0) ? 1 : WIDTH / STAGES;

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end
  endgenerate

  // Per-stage state: valid, carry out of the chunk, sum bits so far, operands still needed.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             cry_q [STAGES];
  logic             cry_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
`ifdef PIPE_ADDER_OVF_EN
  logic             cmsb_q;
  logic             cmsb_d;
`endif

  logic             adv;
  logic             src_v;
  logic             src_c;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_s;
  logic             rc;

  // Whole pipe advances together unless the output slot is full and not taken.
  always_comb begin
    adv      = ~vld_q[STAGES-1] | out_ready;
    in_ready = adv;
  end

  // Next state: each stage adds its chunk on top of the previous stage's register.
  always_comb begin
    vld_d = vld_q;
    cry_d = cry_q;
    sum_d = sum_q;
    a_d   = a_q;
    b_d   = b_q;
`ifdef PIPE_ADDER_OVF_EN
    cmsb_d = cmsb_q;
`endif
    src_v = 1'b0;
    src_c = 1'b0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    rc    = 1'b0;
    if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          src_v = in_valid;
          src_c = cin;
          src_a = a;
          src_b = b;
          src_s = '0;
        end else begin
          src_v = vld_q[k-1];
          src_c = cry_q[k-1];
          src_a = a_q[k-1];
          src_b = b_q[k-1];
          src_s = sum_q[k-1];
        end
        rc       = src_c;
        sum_d[k] = src_s;
        // Chain of full-adder cells across this stage's chunk.
        for (int unsigned i = 0; i < CHUNK; i++) begin
          sum_d[k][k*CHUNK+i] = src_a[k*CHUNK+i] ^ src_b[k*CHUNK+i] ^ rc;
`ifdef PIPE_ADDER_OVF_EN
          if (k == STAGES-1 && i == CHUNK-1) begin
            cmsb_d = rc;
          end
`endif
          rc = (src_a[k*CHUNK+i] & src_b[k*CHUNK+i]) |
               (rc & (src_a[k*CHUNK+i] ^ src_b[k*CHUNK+i]));
        end
        vld_d[k] = src_v;
        cry_d[k] = rc;
        a_d[k]   = src_a;
        b_d[k]   = src_b;
      end
    end
  end

  // Stage registers; async reset clears valids, carries and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
`ifdef PIPE_ADDER_OVF_EN
      cmsb_q <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      sum_q <= sum_d;
      a_q   <= a_d;
      b_q   <= b_d;
`ifdef PIPE_ADDER_OVF_EN
      cmsb_q <= cmsb_d;
`endif
    end
  end

  // Outputs come straight from the last stage register.
  always_comb begin
    out_valid = vld_q[STAGES-1];
    sum       = sum_q[STAGES-1];
    cout      = cry_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    ovf       = cmsb_q ^ cry_q[STAGES-1];
`endif
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 32/4 main instance plus 8/1 and 8/8 instances.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  // Small instances (shared operands, separate readies)
  logic         rst8_n, in_valid8, c8;
  logic [7:0]   a8, b8, sum1, sum8;
  logic         in_ready1, out_valid1, out_ready1, cout1;
  logic         in_ready8, out_valid8, out_ready8, cout8;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf, ovf1, ovf8;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready1),
    .a(a8), .b(b8), .cin(c8), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(c8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer addition, {ovf, cout, sum}.
  function automatic logic [W+1:0] model32(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {o, t};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    o = (x[7] == y[7]) && (t[7] != x[7]);
    return {o, t};
  endfunction

  // Scoreboards: push on accepted input, pop on delivered output.
  logic [W+1:0] q32[$];
  logic [9:0]   q1[$];
  logic [9:0]   q8[$];
  logic [W+1:0] e32;
  logic [9:0]   e1, e8;
  int n_in32 = 0, n_out32 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out32++;
        if (q32.size() == 0) chk("unexpected_out32", 1'b1, 1'b0);
        else begin
          e32 = q32.pop_front();
          chk("sb32_sum", sum, e32[W-1:0]);
          chk("sb32_cout", cout, e32[W]);
`ifdef PIPE_ADDER_OVF_EN
          chk("sb32_ovf", ovf, e32[W+1]);
`endif
        end
      end
      if (in_valid && in_ready) begin
        n_in32++;
        q32.push_back(model32(a, b, cin));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst8_n) begin
      q1.delete();
      q8.delete();
    end else begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) chk("unexpected_out_s1", 1'b1, 1'b0);
        else begin
          e1 = q1.pop_front();
          chk("sb_s1", {cout1, sum1}, e1[8:0]);
`ifdef PIPE_ADDER_OVF_EN
          chk("sb_s1_ovf", ovf1, e1[9]);
`endif
        end
      end
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) chk("unexpected_out_s8", 1'b1, 1'b0);
        else begin
          e8 = q8.pop_front();
          chk("sb_s8", {cout8, sum8}, e8[8:0]);
`ifdef PIPE_ADDER_OVF_EN
          chk("sb_s8_ovf", ovf8, e8[9]);
`endif
        end
      end
      if (in_valid8 && in_ready1) q1.push_back(model8(a8, b8, c8));
      if (in_valid8 && in_ready8) q8.push_back(model8(a8, b8, c8));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[9];
  int   lat, run, maxrun, nv, out0;
  logic [W-1:0] hs;
  logic         hc;

  initial begin
    tbl[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0};
    tbl[8] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    rst8_n = 1'b0; in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    out_ready1 = 1'b1; out_ready8 = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rst8_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // Table vectors, one at a time, with latency measured
    for (int t = 0; t < 9; t++) begin
      in_valid = 1'b1; a = tbl[t].a; b = tbl[t].b; cin = tbl[t].cin;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("tbl%0d_latency", t), lat, S);
      chk($sformatf("tbl%0d_sum", t), sum, tbl[t].s);
      chk($sformatf("tbl%0d_cout", t), cout, tbl[t].co);
`ifdef PIPE_ADDER_OVF_EN
      chk($sformatf("tbl%0d_ovf", t), ovf, tbl[t].ov);
`endif
      tick();
    end

    // Back-to-back stream of 16 random operations
    out0 = n_out32;
    run = 0; maxrun = 0;
    for (int i = 0; i < 16 + S + 4; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("stream_consecutive", maxrun, 16);
    chk("stream_count", n_out32 - out0, 16);

    // Stall with a full pipe
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    hs = sum; hc = cout;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_sum", sum, hs);
      chk("stall_cout", cout, hc);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (S + 4) tick();
    chk("stall_drained", q32.size(), 0);

    // Random valid/ready mix
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 4) tick();
    chk("mix_in_out_balance", n_out32, n_in32);

    // Reset mid-stream with 3 operations in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) nv++;
    end
    chk("midrst_no_emit", nv, 0);

    // WIDTH=8, STAGES=1 and STAGES=8 random sweep with corners first
    for (int i = 0; i < 3000; i++) begin
      case (i)
        0: begin a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; end
        1: begin a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; end
        2: begin a8 = 8'h7F; b8 = 8'h7F; c8 = 1'b0; end
        3: begin a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; end
        4: begin a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; end
        default: begin a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); end
      endcase
      in_valid8  = (i < 16) ? 1'b1 : ($urandom_range(3) != 0);
      out_ready1 = (i < 16) ? 1'b1 : ($urandom_range(3) != 0);
      out_ready8 = (i < 16) ? 1'b1 : ($urandom_range(3) != 0);
      tick();
    end
    in_valid8 = 1'b0; out_ready1 = 1'b1; out_ready8 = 1'b1;
    repeat (12) tick();
    chk("s1_drained", q1.size(), 0);
    chk("s8_drained", q8.size(), 0);

    // Latency of the small instances
    in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    chk("s1_latency", out_valid1, 1'b1);
    chk("s1_sum", {cout1, sum1}, 9'h100);
    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("s8_latency_%0d", j), out_valid8, (j == 8));
      if (j < 8) tick();
    end
    chk("s8_sum", {cout8, sum8}, 9'h100);
    repeat (4) tick();

    chk("final_q32_empty", q32.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
